// File: rtl/spin_ctrl.sv
// Game sequencer for the LED spinner: tick prescaler, button debouncer and the
// IDLE/SPIN/BRAKE/SHOW phase machine that drives the wheel stop and scores wins.
module spin_ctrl #(
  parameter int          TICK_DIV       = 2500,
  parameter int          DEBOUNCE_TICKS = 200,
  parameter int          MIN_SPIN_TICKS = 2000,
  parameter int          BRAKE_TIMEOUT  = 60000,
  parameter int          SHOW_TICKS     = 20000,
  parameter logic [2:0]  TARGET_POS     = 3'd0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  input  logic       running_i,
  input  logic [2:0] pos_i,
  output logic       tick_o,
  output logic       stop_o,
  output logic [1:0] state_o,
  output logic       result_valid_o,
  output logic [2:0] result_pos_o,
  output logic       win_o,
  output logic       timeout_o,
  output logic [7:0] score_o
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int PH_MAX = (MIN_SPIN_TICKS > BRAKE_TIMEOUT)
                          ? ((MIN_SPIN_TICKS > SHOW_TICKS) ? MIN_SPIN_TICKS : SHOW_TICKS)
                          : ((BRAKE_TIMEOUT > SHOW_TICKS) ? BRAKE_TIMEOUT : SHOW_TICKS);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [PH_W-1:0]  MIN_SPIN_C = PH_W'(MIN_SPIN_TICKS);
  localparam logic [PH_W-1:0]  BRAKE_C    = PH_W'(BRAKE_TIMEOUT);
  localparam logic [PH_W-1:0]  SHOW_C     = PH_W'(SHOW_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    BRAKE = 2'd2,
    SHOW  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- prescaler
  logic [DIV_W-1:0] div_reg;
  logic             tick_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (div_reg == DIV_LAST);
      div_reg  <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    end
  end

  // -------------------------------------------------------------- button path
  logic            sync1_reg;
  logic            btn_s_reg;
  logic            btn_db_reg;
  logic            btn_db_dly_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            press;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_reg      <= 1'b0;
      btn_s_reg      <= 1'b0;
      btn_db_reg     <= 1'b0;
      btn_db_dly_reg <= 1'b0;
      db_cnt_reg     <= '0;
    end else begin
      sync1_reg      <= btn_i;
      btn_s_reg      <= sync1_reg;
      btn_db_dly_reg <= btn_db_reg;
      // The count only survives while the synchronized level keeps disagreeing.
      if (btn_s_reg == btn_db_reg) begin
        db_cnt_reg <= '0;
      end else if (tick_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          btn_db_reg <= btn_s_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end
    end
  end

  assign press = btn_db_reg & ~btn_db_dly_reg;

  // ------------------------------------------------------------ phase machine
  state_t          state_reg;
  state_t          state_next;
  logic [PH_W-1:0] phase_reg;
  logic            latch_result;
  logic            set_timeout;
  logic            clear_result;

  always_comb begin
    state_next   = state_reg;
    latch_result = 1'b0;
    set_timeout  = 1'b0;
    clear_result = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press) begin
          state_next   = SPIN;
          clear_result = 1'b1;
        end
      end
      SPIN: begin
        if (press && (phase_reg >= MIN_SPIN_C)) begin
          state_next = BRAKE;
        end
      end
      BRAKE: begin
        // A stopped wheel takes priority over an expiring timeout.
        if (!running_i) begin
          state_next   = SHOW;
          latch_result = 1'b1;
        end else if (phase_reg >= BRAKE_C) begin
          state_next  = SHOW;
          set_timeout = 1'b1;
        end
      end
      SHOW: begin
        if (phase_reg >= SHOW_C) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic       stop_reg;
  logic       result_valid_reg;
  logic [2:0] result_pos_reg;
  logic       win_reg;
  logic       timeout_reg;
  logic [7:0] score_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      phase_reg        <= '0;
      stop_reg         <= 1'b1;
      result_valid_reg <= 1'b0;
      result_pos_reg   <= 3'd0;
      win_reg          <= 1'b0;
      timeout_reg      <= 1'b0;
      score_reg        <= 8'd0;
    end else begin
      state_reg        <= state_next;
      stop_reg         <= (state_next != SPIN);
      result_valid_reg <= latch_result;

      if (state_next != state_reg) begin
        phase_reg <= '0;
      end else if (tick_reg && (phase_reg != {PH_W{1'b1}})) begin
        phase_reg <= phase_reg + PH_W'(1);
      end

      if (clear_result) begin
        result_pos_reg <= 3'd0;
        win_reg        <= 1'b0;
        timeout_reg    <= 1'b0;
      end
      if (latch_result) begin
        result_pos_reg <= pos_i;
        win_reg        <= (pos_i == TARGET_POS);
        if ((pos_i == TARGET_POS) && (score_reg != 8'hFF)) begin
          score_reg <= score_reg + 8'd1;
        end
      end
      if (set_timeout) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign tick_o         = tick_reg;
  assign stop_o         = stop_reg;
  assign state_o        = state_reg;
  assign result_valid_o = result_valid_reg;
  assign result_pos_o   = result_pos_reg;
  assign win_o          = win_reg;
  assign timeout_o      = timeout_reg;
  assign score_o        = score_reg;

endmodule

// File: tb/tb_spin_ctrl.sv
// Randomized game sessions against spin_ctrl; a driver queues expected phase
// changes and results, an independent monitor pops and compares them.
module tb_spin_ctrl;
  localparam int         TICK_DIV = 4;
  localparam int         DEB      = 2;
  localparam int         MIN_SPIN = 5;
  localparam int         BRAKE_TO = 10;
  localparam int         SHOW_T   = 6;
  localparam logic [2:0] TARGET   = 3'd3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       btn_i = 1'b0;
  logic       running_i = 1'b0;
  logic [2:0] pos_i = 3'd0;
  logic       tick_o, stop_o, result_valid_o, win_o, timeout_o;
  logic [1:0] state_o;
  logic [2:0] result_pos_o;
  logic [7:0] score_o;

  spin_ctrl #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEB), .MIN_SPIN_TICKS(MIN_SPIN),
    .BRAKE_TIMEOUT(BRAKE_TO), .SHOW_TICKS(SHOW_T), .TARGET_POS(TARGET)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i), .running_i(running_i),
    .pos_i(pos_i), .tick_o(tick_o), .stop_o(stop_o), .state_o(state_o),
    .result_valid_o(result_valid_o), .result_pos_o(result_pos_o),
    .win_o(win_o), .timeout_o(timeout_o), .score_o(score_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int to;
    int pos;
    int win;
    int score;
  } exp_t;

  exp_t res_q[$];
  int   st_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tk = 0;
  int   model_score = 0;
  int   cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Posedges since reset release; the first tick is due at posedge TICK_DIV.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // ------------------------------------------------------------------ monitor
  int   prev_state = 0;
  int   show_ticks = 0;
  int   brake_ticks = 0;
  int   last_brake = 0;
  int   prev_valid = 0;
  int   prev_to = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_state  = 0;
        show_ticks  = 0;
        brake_ticks = 0;
        prev_valid  = 0;
        prev_to     = 0;
      end else begin
        if (int'(tick_o) != int'(cyc > 0 && (cyc % TICK_DIV) == 0))
          check("tick_period", int'(tick_o), int'(cyc > 0 && (cyc % TICK_DIV) == 0));
        else
          tests++;
        if (int'(stop_o) != int'(state_o != 2'd1))
          check("stop_vs_state", int'(stop_o), int'(state_o != 2'd1));
        else
          tests++;
        if (int'(state_o) != prev_state) begin
          if (st_q.size() == 0) check("state_unexpected", int'(state_o), -1);
          else                  check("state_seq", int'(state_o), st_q.pop_front());
          if (prev_state == 3 && state_o == 2'd0)
            check("show_ticks", show_ticks, SHOW_T);
          last_brake  = brake_ticks;
          show_ticks  = 0;
          brake_ticks = 0;
          prev_state  = int'(state_o);
        end
        if (tick_o) begin
          if (state_o == 2'd3) show_ticks++;
          if (state_o == 2'd2) brake_ticks++;
        end
        if (result_valid_o) begin
          check("valid_one_cycle", prev_valid, 0);
          if (res_q.size() == 0) begin
            check("result_unexpected", int'(result_pos_o), -1);
          end else begin
            mon_e = res_q.pop_front();
            check("res_timeout_flag", int'(timeout_o), mon_e.to);
            check("res_pos", int'(result_pos_o), mon_e.pos);
            check("res_win", int'(win_o), mon_e.win);
            check("res_score", int'(score_o), mon_e.score);
            check("res_state", int'(state_o), 3);
          end
        end
        if (timeout_o && prev_to == 0) begin
          if (res_q.size() == 0) begin
            check("timeout_unexpected", int'(timeout_o), 0);
          end else begin
            mon_e = res_q.pop_front();
            check("to_no_valid", int'(result_valid_o), (mon_e.to != 0) ? 0 : 1);
            check("to_win", int'(win_o), mon_e.win);
            check("to_pos", int'(result_pos_o), mon_e.pos);
            check("to_score", int'(score_o), mon_e.score);
            check("to_brake_ticks", last_brake, BRAKE_TO);
          end
        end
        prev_valid = int'(result_valid_o);
        prev_to    = int'(timeout_o);
      end
    end
  end

  // ------------------------------------------------------------------- driver
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tick_o && n < 3 * TICK_DIV);
    if (!tick_o) check("tick_wait", int'(tick_o), 1);
    tk++;
  endtask

  task automatic wait_state(input int s);
    int n = 0;
    while (int'(state_o) != s && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (int'(state_o) != s) check("wait_state", int'(state_o), s);
  endtask

  // Raised on a tick cycle: debounced high two ticks later, released and
  // debounced low two ticks after that.
  task automatic press_hold();
    btn_i = 1'b1;
    repeat (2) wait_tick();
    btn_i = 1'b0;
    repeat (2) wait_tick();
  endtask

  // Each bounce is seen high on exactly one tick, then matches again.
  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      btn_i = 1'b1;
      wait_tick();
      btn_i = 1'b0;
      repeat ($urandom_range(1, 2)) wait_tick();
    end
  endtask

  // Negative arguments mean "pick at random". Gap and drop offsets are in
  // ticks counted from the tick on which the relevant press starts.
  task automatic play_game(input int e_in, input int r_in, input int pos_in, input int off_in);
    int   t0, s, r, off, pos, attempt, extra, win;
    bit   honoured;
    exp_t e;
    wait_tick();
    bounce($urandom_range(1, 3));
    st_q.push_back(1);
    t0 = tk;
    press_hold();
    running_i = 1'b1;
    attempt = 0;
    honoured = 1'b0;
    while (!honoured) begin
      if (attempt == 0 && e_in >= 0) extra = e_in;
      else if (attempt >= 2)         extra = 2;
      else                           extra = $urandom_range(0, 4);
      repeat (extra) wait_tick();
      s = tk;
      // A press starting g ticks after the spin-starting press sees a count of g.
      honoured = (s - t0) >= MIN_SPIN;
      if (!honoured) begin
        $display("[TB] game press at spin count %0d: expect ignored", s - t0);
        press_hold();
      end
      attempt++;
    end
    st_q.push_back(2);
    r   = (r_in >= 0)   ? r_in   : $urandom_range(4, 14);
    off = (off_in >= 0) ? off_in : $urandom_range(0, 1);
    pos = (pos_in >= 0) ? pos_in : $urandom_range(0, 7);
    pos_i = pos[2:0];
    // Brake count reaches BRAKE_TO with the tick s+BRAKE_TO+2; a drop seen on
    // or before the following cycle still produces a result.
    if (r <= BRAKE_TO + 2) begin
      win = (pos == int'(TARGET)) ? 1 : 0;
      if (win == 1 && model_score < 255) model_score++;
      e.to = 0; e.pos = pos; e.win = win; e.score = model_score;
    end else begin
      e.to = 1; e.pos = 0; e.win = 0; e.score = model_score;
    end
    res_q.push_back(e);
    st_q.push_back(3);
    st_q.push_back(0);
    $display("[TB] game brake press at count %0d, drop at %0d+%0d, pos %0d, expect %s score %0d",
             s - t0, r, off, pos, (e.to != 0) ? "timeout" : "result", e.score);
    press_hold();
    while (tk < s + r) wait_tick();
    if (off != 0) @(negedge clk_i);
    running_i = 1'b0;
    wait_state(0);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1;
    check("rst_tick", int'(tick_o), 0);
    check("rst_stop", int'(stop_o), 1);
    check("rst_state", int'(state_o), 0);
    check("rst_valid", int'(result_valid_o), 0);
    check("rst_pos", int'(result_pos_o), 0);
    check("rst_win", int'(win_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    check("rst_score", int'(score_o), 0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;

    play_game(1, 5, 3, 0);    // earliest honoured stop, winning slot
    play_game(0, 6, 5, 0);    // first stop press too early, losing slot
    play_game(-1, 14, 3, 0);  // wheel never stops in time
    play_game(-1, 12, 3, 1);  // stop and timeout on the same cycle
    play_game(-1, 13, 3, 0);  // one tick too late
    for (int g = 0; g < 8; g++) play_game(-1, -1, -1, -1);

    // Reset asserted mid-spin, between clock edges.
    wait_tick();
    st_q.push_back(1);
    press_hold();
    running_i = 1'b1;
    wait_state(1);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_stop", int'(stop_o), 1);
    check("midrst_state", int'(state_o), 0);
    check("midrst_score", int'(score_o), 0);
    check("midrst_tick", int'(tick_o), 0);
    check("midrst_timeout", int'(timeout_o), 0);
    st_q.delete();
    res_q.delete();
    model_score = 0;
    running_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    play_game(2, 6, 3, 0);    // score restarts from zero

    check("res_q_drained", res_q.size(), 0);
    check("st_q_drained", st_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
